// File: rtl/btb_updater.sv
// Branch resolution check and coalescing BTB write queue.
// Optional statistics counters are enabled with `define BTB_UPDATER_STATS_EN.
module btb_updater #(
  parameter int INDEX_WIDTH = 6,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   res_valid_i,
  input  logic [31:0]            res_pc_i,
  input  logic                   res_taken_i,
  input  logic [31:0]            res_target_i,
  input  logic                   pred_taken_i,
  input  logic [31:0]            pred_target_i,
  output logic                   mispredict_o,
  output logic [31:0]            redirect_pc_o,
  output logic                   btb_wren_o,
  input  logic                   btb_wr_ready_i,
  output logic [INDEX_WIDTH-1:0] btb_wr_index_o,
  output logic [29-INDEX_WIDTH:0] btb_wr_tag_o,
  output logic [31:0]            btb_wr_target_o,
  output logic                   q_full_o,
  output logic                   q_empty_o
`ifdef BTB_UPDATER_STATS_EN
  ,
  output logic [31:0]            stat_resolved_o,
  output logic [31:0]            stat_mispred_o,
  output logic [31:0]            stat_dropped_o
`endif
);

  localparam int TW = 30 - INDEX_WIDTH;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);

  logic [INDEX_WIDTH-1:0] idx_p1 [QUEUE_DEPTH];
  logic [TW-1:0]          tag_p1 [QUEUE_DEPTH];
  logic [31:0]            tgt_p1 [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] vld_p1;
  logic [PW-1:0]          head_q, tail_q;
  logic [CW-1:0]          cnt_q;

  logic [INDEX_WIDTH-1:0] upd_idx_p0;
  logic [TW-1:0]          upd_tag_p0;
  logic                   tgt_diff_p0;
  logic                   upd_p0;
  logic                   deq;
  logic                   hit;
  logic [PW-1:0]          hit_ptr;
  logic                   enq;
  logic                   drop;
  logic                   wr_en;
  logic [PW-1:0]          wr_ptr;

  // Stage p0: resolution compare and queue lookup
  assign upd_idx_p0    = res_pc_i[INDEX_WIDTH+1:2];
  assign upd_tag_p0    = res_pc_i[31:INDEX_WIDTH+2];
  assign tgt_diff_p0   = (res_target_i != pred_target_i);
  assign mispredict_o  = res_valid_i & ((res_taken_i != pred_taken_i) |
                                        (res_taken_i & pred_taken_i & tgt_diff_p0));
  assign redirect_pc_o = res_taken_i ? res_target_i : res_pc_i + 32'd4;
  assign upd_p0        = res_valid_i & res_taken_i & (~pred_taken_i | tgt_diff_p0);

  assign deq = btb_wren_o & btb_wr_ready_i;

  // The head leaving this cycle is excluded so a same-index update survives as a new entry.
  always_comb begin
    hit     = 1'b0;
    hit_ptr = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (vld_p1[i] && (idx_p1[i] == upd_idx_p0) && !(deq && (PW'(i) == head_q))) begin
        hit     = 1'b1;
        hit_ptr = PW'(i);
      end
    end
  end

  assign enq    = upd_p0 & ~hit & ((cnt_q != FULL_CNT) | deq);
  assign drop   = upd_p0 & ~hit & (cnt_q == FULL_CNT) & ~deq;
  assign wr_en  = upd_p0 & (hit | enq);
  assign wr_ptr = hit ? hit_ptr : tail_q;

  // Stage p1: write queue state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_p1 <= '0;
    end else begin
      if (deq) begin
        vld_p1[head_q] <= 1'b0;
        head_q         <= head_q + PW'(1);
      end
      if (enq) begin
        vld_p1[tail_q] <= 1'b1;
        tail_q         <= tail_q + PW'(1);
      end
      cnt_q <= cnt_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      idx_p1[wr_ptr] <= upd_idx_p0;
      tag_p1[wr_ptr] <= upd_tag_p0;
      tgt_p1[wr_ptr] <= res_target_i;
    end
  end

  // Head fields change only on dequeue or when a new update coalesces into the head.
  assign btb_wren_o      = (cnt_q != '0);
  assign q_empty_o       = (cnt_q == '0);
  assign q_full_o        = (cnt_q == FULL_CNT);
  assign btb_wr_index_o  = idx_p1[head_q];
  assign btb_wr_tag_o    = tag_p1[head_q];
  assign btb_wr_target_o = tgt_p1[head_q];

`ifdef BTB_UPDATER_STATS_EN
  logic [31:0] stat_resolved_q, stat_mispred_q, stat_dropped_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
      stat_dropped_q  <= '0;
    end else begin
      if (res_valid_i)  stat_resolved_q <= stat_resolved_q + 32'd1;
      if (mispredict_o) stat_mispred_q  <= stat_mispred_q + 32'd1;
      if (drop)         stat_dropped_q  <= stat_dropped_q + 32'd1;
    end
  end

  assign stat_resolved_o = stat_resolved_q;
  assign stat_mispred_o  = stat_mispred_q;
  assign stat_dropped_o  = stat_dropped_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_btb_updater.sv
// Scoreboard bench for btb_updater (default build, statistics disabled).
module tb_btb_updater;
  localparam int IW = 6;
  localparam int TW = 30 - IW;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [31:0]   tgt;
  } ent_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          res_valid_i, res_taken_i, pred_taken_i, btb_wr_ready_i;
  logic [31:0]   res_pc_i, res_target_i, pred_target_i;
  logic          mispredict_o, btb_wren_o, q_full_o, q_empty_o;
  logic [31:0]   redirect_pc_o, btb_wr_target_o;
  logic [IW-1:0] btb_wr_index_o;
  logic [TW-1:0] btb_wr_tag_o;

  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];

  btb_updater #(.INDEX_WIDTH(IW), .QUEUE_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .res_valid_i(res_valid_i), .res_pc_i(res_pc_i), .res_taken_i(res_taken_i),
    .res_target_i(res_target_i), .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .btb_wren_o(btb_wren_o), .btb_wr_ready_i(btb_wr_ready_i),
    .btb_wr_index_o(btb_wr_index_o), .btb_wr_tag_o(btb_wr_tag_o),
    .btb_wr_target_o(btb_wr_target_o), .q_full_o(q_full_o), .q_empty_o(q_empty_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] tgt);
    ent_t e;
    e.idx = pc[IW+1:2];
    e.tag = pc[31:IW+2];
    e.tgt = tgt;
    return e;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    res_valid_i = v; res_pc_i = pc; res_taken_i = tk;
    res_target_i = tgt; pred_taken_i = ptk; pred_target_i = ptgt;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (btb_wren_o !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b exp=0", btb_wren_o); end
    checks++; if (q_empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", q_empty_o); end
    checks++; if (q_full_o !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", q_full_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_mispredict();
    ent_t e;
    @(negedge clk_i);
    btb_wr_ready_i = 1'b0;
    drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    checks++; if (mispredict_o !== 1'b1) begin errors++; $display("FAIL mp_taken got=%b exp=1", mispredict_o); end
    checks++; if (redirect_pc_o !== 32'h200) begin errors++; $display("FAIL mp_redirect got=%h exp=200", redirect_pc_o); end
    checks++; if (btb_wren_o !== 1'b0) begin errors++; $display("FAIL mp_no_bypass got=%b exp=0", btb_wren_o); end
    sb.push_back(mk(32'h100, 32'h200));
    tick();
    idle();
    #1;
    checks++; if (btb_wren_o !== 1'b1) begin errors++; $display("FAIL mp_wren got=%b exp=1", btb_wren_o); end
    btb_wr_ready_i = 1'b1;
    #1;
    e = sb.pop_front();
    checks++;
    if ({btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o} !== e) begin
      errors++; $display("FAIL mp_entry got=%h/%h/%h exp=%h/%h/%h", btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o, e.idx, e.tag, e.tgt);
    end
    tick();
    btb_wr_ready_i = 1'b0;
    #1;
    checks++; if (q_empty_o !== 1'b1) begin errors++; $display("FAIL mp_drained got=%b exp=1", q_empty_o); end
  endtask

  task automatic test_not_taken();
    @(negedge clk_i);
    drive(1'b1, 32'h104, 1'b0, 32'h0, 1'b1, 32'h300);
    #1;
    checks++; if (mispredict_o !== 1'b1) begin errors++; $display("FAIL nt_mp got=%b exp=1", mispredict_o); end
    checks++; if (redirect_pc_o !== 32'h108) begin errors++; $display("FAIL nt_redirect got=%h exp=108", redirect_pc_o); end
    tick();
    drive(1'b1, 32'h240, 1'b1, 32'h400, 1'b1, 32'h400);
    #1;
    checks++; if (mispredict_o !== 1'b0) begin errors++; $display("FAIL ok_mp got=%b exp=0", mispredict_o); end
    checks++; if (q_empty_o !== 1'b1) begin errors++; $display("FAIL nt_empty got=%b exp=1", q_empty_o); end
    tick();
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checks++; if (mispredict_o !== 1'b0) begin errors++; $display("FAIL nt_ok_mp got=%b exp=0", mispredict_o); end
    checks++; if (redirect_pc_o !== 32'h0) begin errors++; $display("FAIL nt_wrap got=%h exp=0", redirect_pc_o); end
    tick();
    idle();
    #1;
    checks++; if (q_empty_o !== 1'b1) begin errors++; $display("FAIL ok_empty got=%b exp=1", q_empty_o); end
  endtask

  task automatic test_coalesce();
    ent_t e;
    int   n;
    @(negedge clk_i);
    btb_wr_ready_i = 1'b0;
    drive(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    #1;
    checks++; if (mispredict_o !== 1'b1) begin errors++; $display("FAIL co_mp got=%b exp=1", mispredict_o); end
    tick();
    idle();
    sb.push_back(mk(32'h100, 32'h300));
    #1;
    checks++; if (btb_wr_target_o !== 32'h300) begin errors++; $display("FAIL co_target got=%h exp=300", btb_wr_target_o); end
    btb_wr_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (btb_wren_o === 1'b1) begin
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        n++;
        checks++;
        if ({btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o} !== e) begin
          errors++; $display("FAIL co_entry got=%h/%h/%h exp=%h/%h/%h", btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o, e.idx, e.tag, e.tgt);
        end
      end
      tick();
    end
    btb_wr_ready_i = 1'b0;
    checks++; if (n !== 1) begin errors++; $display("FAIL co_count got=%0d exp=1", n); end
  endtask

  task automatic test_full_drop();
    ent_t e, h;
    int   n;
    @(negedge clk_i);
    btb_wr_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'h1000 + 32'(4 * k), 1'b1, 32'h8000 + 32'(16 * k), 1'b0, 32'h0);
      if (k < 4) sb.push_back(mk(32'h1000 + 32'(4 * k), 32'h8000 + 32'(16 * k)));
      #1;
      if (k == 4) begin
        checks++; if (q_full_o !== 1'b1) begin errors++; $display("FAIL fd_full got=%b exp=1", q_full_o); end
      end
      tick();
    end
    idle();
    #1;
    h = sb[0];
    checks++; if (q_full_o !== 1'b1) begin errors++; $display("FAIL fd_full_after got=%b exp=1", q_full_o); end
    checks++;
    if ({btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o} !== h) begin
      errors++; $display("FAIL fd_hold got=%h/%h exp=%h/%h", btb_wr_index_o, btb_wr_target_o, h.idx, h.tgt);
    end
    btb_wr_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (btb_wren_o === 1'b1) begin
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        n++;
        checks++;
        if ({btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o} !== e) begin
          errors++; $display("FAIL fd_entry%0d got=%h/%h/%h exp=%h/%h/%h", n, btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o, e.idx, e.tag, e.tgt);
        end
      end else if (n > 0 && n < 4) begin
        checks++; errors++; $display("FAIL fd_gap got=%0d exp=4 consecutive", n);
      end
      tick();
    end
    btb_wr_ready_i = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL fd_count got=%0d exp=4", n); end
  endtask

  task automatic test_full_deq();
    ent_t e;
    int   n;
    @(negedge clk_i);
    btb_wr_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h2000 + 32'(4 * k), 1'b1, 32'h9000 + 32'(8 * k), 1'b0, 32'h0);
      sb.push_back(mk(32'h2000 + 32'(4 * k), 32'h9000 + 32'(8 * k)));
      tick();
    end
    btb_wr_ready_i = 1'b1;
    drive(1'b1, 32'h2000, 1'b1, 32'hA000, 1'b0, 32'h0);
    #1;
    e = sb.pop_front();
    checks++;
    if ({btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o} !== e) begin
      errors++; $display("FAIL fq_head0 got=%h/%h exp=%h/%h", btb_wr_index_o, btb_wr_target_o, e.idx, e.tgt);
    end
    sb.push_back(mk(32'h2000, 32'hA000));
    tick();
    idle();
    btb_wr_ready_i = 1'b0;
    #1;
    checks++; if (q_full_o !== 1'b1) begin errors++; $display("FAIL fq_full got=%b exp=1", q_full_o); end
    btb_wr_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (btb_wren_o === 1'b1) begin
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        n++;
        checks++;
        if ({btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o} !== e) begin
          errors++; $display("FAIL fq_entry%0d got=%h/%h/%h exp=%h/%h/%h", n, btb_wr_index_o, btb_wr_tag_o, btb_wr_target_o, e.idx, e.tag, e.tgt);
        end
      end
      tick();
    end
    btb_wr_ready_i = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL fq_count got=%0d exp=4", n); end
  endtask

  task automatic test_reset_mid();
    int writes;
    @(negedge clk_i);
    btb_wr_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h3000 + 32'(4 * k), 1'b1, 32'h7000, 1'b0, 32'h0);
      tick();
    end
    idle();
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (btb_wren_o !== 1'b0) begin errors++; $display("FAIL rm_wren got=%b exp=0", btb_wren_o); end
    checks++; if (q_empty_o !== 1'b1) begin errors++; $display("FAIL rm_empty got=%b exp=1", q_empty_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    btb_wr_ready_i = 1'b1;
    writes = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (btb_wren_o !== 1'b0) writes++;
      tick();
    end
    btb_wr_ready_i = 1'b0;
    checks++; if (writes !== 0) begin errors++; $display("FAIL rm_writes got=%0d exp=0", writes); end
  endtask

  initial begin
    rst_ni = 1'b0;
    btb_wr_ready_i = 1'b0;
    idle();
    test_reset();
    test_mispredict();
    test_not_taken();
    test_coalesce();
    test_full_drop();
    test_full_deq();
    test_reset_mid();
    if (sb.size() != 0) begin
      checks++; errors++; $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
